param_sync_fifo: RTL

//   Parametrised single-clock show-ahead FIFO; successor to the fixed 8-bit standard FIFO instance.

---
 rtl/param_sync_fifo.sv | 112 +++++++++++
 1 files changed

// File: rtl/param_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : param_sync_fifo
// Brief    : Single-clock show-ahead FIFO with configurable width, any depth
//            >= 2, almost-full/almost-empty thresholds and error flags.
//            Define PARAM_SYNC_FIFO_STICKY_ERR_EN for sticky error flags.
// Revision : 1.0 - initial release
// ============================================================================
module param_sync_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 1,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_almost_full,
  output logic             o_almost_empty,
  output logic [CW-1:0]    o_word_count,
  output logic             o_overflow,
  output logic             o_underflow
);

  localparam int            PW         = $clog2(DEPTH);
  localparam logic [PW-1:0] c_last_ptr = PW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_pop_ok;
  logic             w_push_ok;
  logic             w_ovf_evt;
  logic             w_unf_evt;

  assign o_empty        = (r_count == '0);
  assign o_full         = (r_count == CW'(DEPTH));
  assign o_almost_full  = (r_count >= CW'(AF_THRESH));
  assign o_almost_empty = (r_count <= CW'(AE_THRESH));
  assign o_word_count   = r_count;
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;
  assign o_data         = o_empty ? '0 : r_mem[r_rptr];

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);
  assign w_ovf_evt = i_push & ~w_push_ok & ~i_clear;
  assign w_unf_evt = i_pop & ~w_pop_ok & ~i_clear;

  always_ff @(posedge i_clk) begin
    if (w_push_ok && !i_clear) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      // Explicit wrap so non-power-of-two depths index correctly.
      if (w_push_ok) begin
        r_wptr <= (r_wptr == c_last_ptr) ? '0 : r_wptr + PW'(1);
      end
      if (w_pop_ok) begin
        r_rptr <= (r_rptr == c_last_ptr) ? '0 : r_rptr + PW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (i_clear) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
`ifdef PARAM_SYNC_FIFO_STICKY_ERR_EN
      r_overflow  <= r_overflow | w_ovf_evt;
      r_underflow <= r_underflow | w_unf_evt;
`else
      r_overflow  <= w_ovf_evt;
      r_underflow <= w_unf_evt;
`endif
    end
  end

endmodule
`default_nettype wire
